gpio_config_loader: RTL



---
 rtl/gpio_config_loader.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/gpio_config_loader.sv
// gpio_config_loader
//   Sequencer for the user-project I/O configuration shift chains. On a start
//   request it fetches one configuration word per pad from the SoC register
//   file and shifts it serially, MSB first, into two chains: chain 1 gets
//   pad 18 first down to pad 0, chain 2 gets pad 19 first up to pad 37. It
//   then strobes loader_load to move the chains into the pad control latches.
//
// Ports
//   clk, reset            : system clock, asynchronous active-high reset
//   start, abort          : one-cycle transfer request / synchronous cancel
//   busy, done            : transfer in progress / one-cycle completion pulse
//   cfg_addr_1/2          : pad index presented to the register file
//   cfg_data_1/2          : combinational read data for cfg_addr_1/2
//   loader_resetn         : chain reset, active-low
//   loader_clock          : chain shift clock
//   loader_data_1/2       : serial data for chain 1 / chain 2
//   loader_load           : latch strobe into the pad control registers
module gpio_config_loader #(
  parameter int unsigned PADS_PER_CHAIN = 19,
  parameter int unsigned CFG_BITS       = 13,
  parameter int unsigned CLK_DIV        = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [5:0]          cfg_addr_1,
  output logic [5:0]          cfg_addr_2,
  input  logic [CFG_BITS-1:0] cfg_data_1,
  input  logic [CFG_BITS-1:0] cfg_data_2,
  output logic                loader_resetn,
  output logic                loader_clock,
  output logic                loader_data_1,
  output logic                loader_data_2,
  output logic                loader_load
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam int unsigned PadW = (PADS_PER_CHAIN > 1) ? $clog2(PADS_PER_CHAIN) : 1;

  localparam logic [DivW-1:0] DivLast    = DivW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitLast    = BitW'(CFG_BITS - 1);
  localparam logic [PadW-1:0] PadLast    = PadW'(PADS_PER_CHAIN - 1);
  localparam logic [5:0]      AddrFirst1 = 6'(PADS_PER_CHAIN - 1);
  localparam logic [5:0]      AddrFirst2 = 6'(PADS_PER_CHAIN);
  localparam logic [5:0]      AddrLast2  = 6'(2 * PADS_PER_CHAIN - 1);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StShiftLo,
    StShiftHi,
    StLoad,
    StFinish
  } state_t;

  state_t              state;
  logic [DivW-1:0]     div_cnt;
  logic [BitW-1:0]     bit_cnt;
  logic [PadW-1:0]     pad_cnt;
  logic [CFG_BITS-1:0] sreg_1;
  logic [CFG_BITS-1:0] sreg_2;

  logic div_last;
  assign div_last = (div_cnt == DivLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= StIdle;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      pad_cnt       <= '0;
      sreg_1        <= '0;
      sreg_2        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cfg_addr_1    <= AddrFirst1;
      cfg_addr_2    <= AddrFirst2;
      loader_resetn <= 1'b0;
      loader_clock  <= 1'b0;
      loader_data_1 <= 1'b0;
      loader_data_2 <= 1'b0;
      loader_load   <= 1'b0;
    end else begin
      // Chain reset is only asserted while dwelling in StClear.
      loader_resetn <= 1'b1;
      done          <= 1'b0;

      // busy is high exactly in StClear..StLoad, so it doubles as the abort qualifier.
      if (busy && abort) begin
        state        <= StIdle;
        busy         <= 1'b0;
        loader_clock <= 1'b0;
        loader_load  <= 1'b0;
        div_cnt      <= '0;
        cfg_addr_1   <= AddrFirst1;
        cfg_addr_2   <= AddrFirst2;
      end else begin
        unique case (state)
          StIdle: begin
            if (start) begin
              state         <= StClear;
              busy          <= 1'b1;
              loader_resetn <= 1'b0;
              div_cnt       <= '0;
              bit_cnt       <= '0;
              pad_cnt       <= '0;
            end
          end

          StClear: begin
            if (div_last) begin
              // Enter the first low phase and capture the first word of each chain.
              state         <= StShiftLo;
              div_cnt       <= '0;
              sreg_1        <= {cfg_data_1[CFG_BITS-2:0], 1'b0};
              sreg_2        <= {cfg_data_2[CFG_BITS-2:0], 1'b0};
              loader_data_1 <= cfg_data_1[CFG_BITS-1];
              loader_data_2 <= cfg_data_2[CFG_BITS-1];
              if (cfg_addr_1 != 6'd0)      cfg_addr_1 <= cfg_addr_1 - 6'd1;
              if (cfg_addr_2 != AddrLast2) cfg_addr_2 <= cfg_addr_2 + 6'd1;
            end else begin
              div_cnt       <= div_cnt + DivW'(1);
              loader_resetn <= 1'b0;
            end
          end

          StShiftLo: begin
            if (div_last) begin
              state        <= StShiftHi;
              div_cnt      <= '0;
              loader_clock <= 1'b1;
            end else begin
              div_cnt <= div_cnt + DivW'(1);
            end
          end

          StShiftHi: begin
            if (div_last) begin
              div_cnt      <= '0;
              loader_clock <= 1'b0;
              if ((bit_cnt == BitLast) && (pad_cnt == PadLast)) begin
                state       <= StLoad;
                loader_load <= 1'b1;
              end else if (bit_cnt == BitLast) begin
                // Word boundary: capture the next pad's word, advance the address.
                state         <= StShiftLo;
                bit_cnt       <= '0;
                pad_cnt       <= pad_cnt + PadW'(1);
                sreg_1        <= {cfg_data_1[CFG_BITS-2:0], 1'b0};
                sreg_2        <= {cfg_data_2[CFG_BITS-2:0], 1'b0};
                loader_data_1 <= cfg_data_1[CFG_BITS-1];
                loader_data_2 <= cfg_data_2[CFG_BITS-1];
                if (cfg_addr_1 != 6'd0)      cfg_addr_1 <= cfg_addr_1 - 6'd1;
                if (cfg_addr_2 != AddrLast2) cfg_addr_2 <= cfg_addr_2 + 6'd1;
              end else begin
                state         <= StShiftLo;
                bit_cnt       <= bit_cnt + BitW'(1);
                sreg_1        <= {sreg_1[CFG_BITS-2:0], 1'b0};
                sreg_2        <= {sreg_2[CFG_BITS-2:0], 1'b0};
                loader_data_1 <= sreg_1[CFG_BITS-1];
                loader_data_2 <= sreg_2[CFG_BITS-1];
              end
            end else begin
              div_cnt <= div_cnt + DivW'(1);
            end
          end

          StLoad: begin
            if (div_last) begin
              state       <= StFinish;
              div_cnt     <= '0;
              loader_load <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
              cfg_addr_1  <= AddrFirst1;
              cfg_addr_2  <= AddrFirst2;
            end else begin
              div_cnt <= div_cnt + DivW'(1);
            end
          end

          StFinish: begin
            state <= StIdle;
          end

          default: begin
            state <= StIdle;
          end
        endcase
      end
    end
  end

endmodule
